fft_band_colorizer: RTL and testbench

//  Upstream of the VGA colour-output stage; produces its 84-bit FFT_COLOR palette (7 x RGB444).

---
 rtl/fft_band_colorizer_pkg.sv | 23 ++
 rtl/fft_band_colorizer_if.sv | 16 +
 rtl/fft_band_colorizer_scale.sv | 28 ++
 rtl/fft_band_colorizer.sv | 129 ++++++++++++
 tb/tb_fft_band_colorizer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fft_band_colorizer_pkg.sv
// Shared constants, state encoding and default band table for the FFT band colorizer.
package fft_color_pkg;

    localparam int unsigned NUM_BANDS = 7;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned PAL_W     = NUM_BANDS * COLOR_W;

    typedef enum logic [0:0] {
        StAccum,
        StMap
    } state_e;

    // Edges E0..E7, E0 in the low slice; DC bin 0 and 1 are left out.
    localparam logic [79:0] DEFAULT_BAND_EDGES = {
        10'd512, 10'd256, 10'd128, 10'd64, 10'd32, 10'd16, 10'd8, 10'd2
    };

    localparam logic [83:0] DEFAULT_BAND_HUES = {
        12'hF0F, 12'h00F, 12'h0FF, 12'h0F0, 12'hFF0, 12'hF80, 12'hF00
    };

endpackage

// File: rtl/fft_band_colorizer_if.sv
// Valid/ready stream of FFT magnitude samples feeding the colorizer.
interface fft_band_colorizer_if #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned MAG_W = 16
);

    logic             valid;
    logic             ready;
    logic [IDX_W-1:0] index;
    logic [MAG_W-1:0] mag;
    logic             last;

    modport master (output valid, output index, output mag, output last, input ready);
    modport slave  (input valid, input index, input mag, input last, output ready);

endinterface

// File: rtl/fft_band_colorizer_scale.sv
// Combinational scaling of an RGB444 hue by a 4-bit intensity level.
module band_color_scale
    import fft_color_pkg::*;
(
    input  logic [COLOR_W-1:0] hue_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               zero_i,
    output logic [COLOR_W-1:0] rgb_o
);

    // (h * (level + 1)) >> 4 keeps the top nibble, so level 15 returns h unchanged.
    function automatic logic [3:0] scale_ch(input logic [3:0] h, input logic [4:0] m);
        return 4'((9'(h) * 9'(m)) >> 4);
    endfunction

    logic [4:0] mult;

    always_comb begin
        mult  = {1'b0, level_i} + 5'd1;
        rgb_o = '0;
        if (!zero_i) begin
            rgb_o = {scale_ch(hue_i[11:8], mult),
                     scale_ch(hue_i[7:4], mult),
                     scale_ch(hue_i[3:0], mult)};
        end
    end

endmodule

// File: rtl/fft_band_colorizer.sv
// Tracks per-band FFT peaks, maps them to a 7-entry RGB444 palette and publishes it on vsync fall.
module fft_band_colorizer
    import fft_color_pkg::*;
#(
    parameter int unsigned           IDX_W      = 10,
    parameter int unsigned           MAG_W      = 16,
    parameter int unsigned           MAG_SHIFT  = 12,
    parameter logic [8*IDX_W-1:0]    BAND_EDGES = DEFAULT_BAND_EDGES,
    parameter logic [PAL_W-1:0]      BAND_HUES  = DEFAULT_BAND_HUES
) (
    input  logic                video_clk,
    input  logic                reset,
    fft_band_colorizer_if.slave fft,
    input  logic                vsync,
    output logic [PAL_W-1:0]    FFT_COLOR,
    output logic                colors_valid
);

    state_e               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [MAG_W-1:0]     peak_q [NUM_BANDS];
    logic [MAG_W-1:0]     peak_d [NUM_BANDS];
    logic [PAL_W-1:0]     shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 vsync_q;
    logic [PAL_W-1:0]     color_q, color_d;
    logic                 cvalid_q, cvalid_d;

    logic [NUM_BANDS-1:0] band_hit;
    logic [MAG_W-1:0]     peak_sel;
    logic [MAG_W-1:0]     peak_shift;
    logic [LEVEL_W-1:0]   level;
    logic [COLOR_W-1:0]   hue_sel;
    logic [COLOR_W-1:0]   rgb;
    logic                 vsync_edge;

    assign fft.ready    = (state_q == StAccum);
    assign FFT_COLOR    = color_q;
    assign colors_valid = cvalid_q;
    assign vsync_edge   = vsync_q & ~vsync;

    // Edges are ascending, so at most one band can match a given index.
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            band_hit[b] = (fft.index >= BAND_EDGES[b*IDX_W +: IDX_W]) &&
                          (fft.index <  BAND_EDGES[(b+1)*IDX_W +: IDX_W]);
        end
    end

    always_comb begin
        peak_sel   = peak_q[k_q];
        peak_shift = peak_sel >> MAG_SHIFT;
        level      = (peak_shift > MAG_W'(15)) ? 4'hF : peak_shift[LEVEL_W-1:0];
        hue_sel    = BAND_HUES[COLOR_W*k_q +: COLOR_W];
    end

    band_color_scale u_scale (
        .hue_i   (hue_sel),
        .level_i (level),
        .zero_i  (peak_sel == '0),
        .rgb_o   (rgb)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        peak_d    = peak_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        color_d   = color_q;
        cvalid_d  = cvalid_q;

        if (vsync_edge && pending_q) begin
            color_d   = shadow_q;
            pending_d = 1'b0;
            cvalid_d  = 1'b1;
        end

        unique case (state_q)
            StAccum: begin
                if (fft.valid) begin
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        if (band_hit[b] && (fft.mag > peak_q[b])) begin
                            peak_d[b] = fft.mag;
                        end
                    end
                    if (fft.last) begin
                        state_d = StMap;
                        k_d     = 3'd0;
                    end
                end
            end
            StMap: begin
                shadow_d[COLOR_W*k_q +: COLOR_W] = rgb;
                peak_d[k_q]                      = '0;
                // A completed frame re-arms pending even if it is being published this cycle.
                if (k_q == 3'(NUM_BANDS - 1)) begin
                    state_d   = StAccum;
                    pending_d = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (reset) begin
            state_q   <= StAccum;
            k_q       <= 3'd0;
            peak_q    <= '{default: '0};
            shadow_q  <= '0;
            pending_q <= 1'b0;
            vsync_q   <= 1'b1;
            color_q   <= '0;
            cvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            peak_q    <= peak_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            vsync_q   <= vsync;
            color_q   <= color_d;
            cvalid_q  <= cvalid_d;
        end
    end

endmodule

// File: tb/tb_fft_band_colorizer.sv
// Directed bench for fft_band_colorizer: peak tracking, scaling, backpressure, coalescing, reset.
module tb_fft_band_colorizer;
    import fft_color_pkg::*;

    localparam logic [79:0] TB_EDGES = {
        10'd512, 10'd128, 10'd64, 10'd32, 10'd16, 10'd8, 10'd4, 10'd1
    };
    localparam logic [83:0] TB_HUES = {
        12'hABC, 12'hF0F, 12'h00F, 12'h0F0, 12'h8C4, 12'hFFF, 12'hF00
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic [83:0] color;
    logic        cvalid;
    int          n_checks = 0;
    int          n_fail = 0;

    fft_band_colorizer_if #(.IDX_W(10), .MAG_W(16)) fft_if ();

    fft_band_colorizer #(
        .IDX_W      (10),
        .MAG_W      (16),
        .MAG_SHIFT  (12),
        .BAND_EDGES (TB_EDGES),
        .BAND_HUES  (TB_HUES)
    ) dut (
        .video_clk    (clk),
        .reset        (reset),
        .fft          (fft_if),
        .vsync        (vsync),
        .FFT_COLOR    (color),
        .colors_valid (cvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] idx, input logic [15:0] mag, input logic last);
        int n = 0;
        fft_if.valid = 1'b1;
        fft_if.index = idx;
        fft_if.mag   = mag;
        fft_if.last  = last;
        while (!fft_if.ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", {83'd0, fft_if.ready}, 84'd1);
        tick();
        fft_if.valid = 1'b0;
        fft_if.last  = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        fft_if.valid = 1'b0;
        fft_if.index = '0;
        fft_if.mag   = '0;
        fft_if.last  = 1'b0;

        // 1. Reset state, vsync with nothing pending
        tick();
        tick();
        reset = 1'b0;
        check("rst_color", color, 84'h0);
        check("rst_valid", {83'd0, cvalid}, 84'd0);
        check("rst_ready", {83'd0, fft_if.ready}, 84'd1);
        vsync_pulse();
        check("rst_vsync_color", color, 84'h0);
        check("rst_vsync_valid", {83'd0, cvalid}, 84'd0);

        // 2. Full level on band 0
        send(10'd1, 16'hFFFF, 1'b1);
        check("full_map_busy", {83'd0, fft_if.ready}, 84'd0);
        repeat (7) tick();
        check("full_map_done", {83'd0, fft_if.ready}, 84'd1);
        check("full_prepub", color, 84'h0);
        vsync_pulse();
        check("full_color", color, 84'hF00);
        check("full_valid", {83'd0, cvalid}, 84'd1);

        // 3. Peak of three in band 1, out-of-range samples ignored, last on ignored index
        send(10'd4, 16'h3000, 1'b0);
        send(10'd5, 16'h7000, 1'b0);
        send(10'd6, 16'h2000, 1'b0);
        send(10'd600, 16'hFFFF, 1'b0);
        send(10'd0, 16'hFFFF, 1'b0);
        send(10'd700, 16'h0000, 1'b1);
        repeat (7) tick();
        vsync_pulse();
        check("mid_color", color, 84'h777000);

        // 4. Backpressure: next frame's sample held valid across MAP
        send(10'd8, 16'hF000, 1'b1);
        fft_if.valid = 1'b1;
        fft_if.index = 10'd5;
        fft_if.mag   = 16'h5000;
        fft_if.last  = 1'b1;
        n = 0;
        while (!fft_if.ready && n < 20) begin
            n++;
            tick();
        end
        check("bp_stall_cycles", 84'(n), 84'd7);
        tick();
        fft_if.valid = 1'b0;
        fft_if.last  = 1'b0;
        check("bp_accepted", {83'd0, fft_if.ready}, 84'd0);
        repeat (7) tick();
        check("bp_map_done", {83'd0, fft_if.ready}, 84'd1);
        tick();
        check("bp_single_accept", {83'd0, fft_if.ready}, 84'd1);
        check("bp_no_edge", color, 84'h777000);
        vsync_pulse();
        check("bp_color", color, 84'h555000);

        // 5. Two frames coalesce into one publish
        send(10'd10, 16'hFFFF, 1'b1);
        repeat (7) tick();
        send(10'd12, 16'h3FFF, 1'b1);
        repeat (7) tick();
        check("coal_held", color, 84'h555000);
        vsync_pulse();
        check("coal_color", color, 84'h231000000);
        vsync_pulse();
        check("coal_second_edge", color, 84'h231000000);
        check("coal_valid", {83'd0, cvalid}, 84'd1);

        // 6. Reset during MAP discards everything
        send(10'd40, 16'hFFFF, 1'b0);
        send(10'd100, 16'hFFFF, 1'b1);
        repeat (3) tick();
        check("mr_in_map", {83'd0, fft_if.ready}, 84'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_ready", {83'd0, fft_if.ready}, 84'd1);
        check("mr_color", color, 84'h0);
        check("mr_valid", {83'd0, cvalid}, 84'd0);
        vsync_pulse();
        check("mr_no_publish", color, 84'h0);
        check("mr_no_valid", {83'd0, cvalid}, 84'd0);
        send(10'd0, 16'h0000, 1'b1);
        repeat (7) tick();
        vsync_pulse();
        check("mr_peaks_cleared", color, 84'h0);
        check("mr_valid_after", {83'd0, cvalid}, 84'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
